mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter_sat_cnt.sv | 19 +
 rtl/mem_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and sizes for the memory arbiter
package mem_arb_defs;

  localparam int MEM_LAT_DEFAULT = 4;
  localparam int CNT_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arbState_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester/memory signal bundle for the arbiter
interface mem_arb_if;
  import mem_arb_defs::*;

  logic             i_req;
  logic [15:0]      i_addr;
  logic             d_req;
  logic             d_wr;
  logic [15:0]      d_addr;
  logic [15:0]      d_wdata;
  logic [15:0]      mem_rdata;
  logic             mem_en;
  logic             mem_wr;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic             i_done;
  logic             d_done;
  logic [15:0]      rdata;
  logic             busy;
  logic [CNT_W-1:0] i_grant_cnt;
  logic [CNT_W-1:0] d_grant_cnt;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, rdata, busy,
           i_grant_cnt, d_grant_cnt
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, rdata, busy,
           i_grant_cnt, d_grant_cnt
  );

endinterface

// File: rtl/mem_arbiter_sat_cnt.sv
// rtl/mem_arbiter_sat_cnt.sv - saturating grant counter
module sat_cnt16
  import mem_arb_defs::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin I/D arbiter in front of a fixed-latency memory
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);

  arbState_t  state;
  grant_t     lastGrant;
  grant_t     curSide;
  logic [3:0] count;
  logic       anyReq;
  logic       pickD;
  logic       grantI;
  logic       grantD;

  // On a tie the side not served last wins; lastGrant resets to I so D wins first.
  always_comb begin
    anyReq = bus.i_req | bus.d_req;
    pickD  = bus.d_req & (~bus.i_req | (lastGrant == GRANT_I));
    grantD = (state == ST_IDLE) & pickD;
    grantI = (state == ST_IDLE) & bus.i_req & ~pickD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      lastGrant     <= GRANT_I;
      curSide       <= GRANT_I;
      count         <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_done    <= 1'b0;
      bus.d_done    <= 1'b0;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.mem_en <= 1'b0;
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (anyReq) begin
            state      <= ST_BUSY;
            count      <= 4'd1;
            bus.mem_en <= 1'b1;
            bus.busy   <= 1'b1;
            if (pickD) begin
              curSide       <= GRANT_D;
              lastGrant     <= GRANT_D;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wr    <= bus.d_wr;
              bus.mem_wdata <= bus.d_wdata;
            end else begin
              curSide       <= GRANT_I;
              lastGrant     <= GRANT_I;
              bus.mem_addr  <= bus.i_addr;
              bus.mem_wr    <= 1'b0;
              bus.mem_wdata <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (count == 4'(MEM_LAT)) begin
            state <= ST_DONE;
            if (!bus.mem_wr) bus.rdata <= bus.mem_rdata;
            if (curSide == GRANT_D) bus.d_done <= 1'b1;
            else                    bus.i_done <= 1'b1;
          end else begin
            count <= count + 4'd1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          count    <= '0;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  sat_cnt16 iCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (grantI),
    .count (bus.i_grant_cnt)
  );

  sat_cnt16 dCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (grantD),
    .count (bus.d_grant_cnt)
  );

endmodule
